// File: rtl/lc_line_responder.sv
// Lower-cache line responder: queues L1 fill/write-back requests in order and services them against a local line store.
// Optional macro LC_RESP_INIT_PATTERN_EN: reads of never-written lines return an address pattern instead of zeros.
module lc_line_responder #(
  parameter int QUEUE_DEPTH = 4,
  parameter int LATENCY     = 8,
  parameter int LINES       = 256,
  parameter int ADDR_BITS   = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 l1_valid_in,
  input  logic [ADDR_BITS-1:0] l1_addr_in,
  input  logic [511:0]         l1_value_in,
  input  logic                 l1_we_in,
  output logic                 l1_ready_out,
  output logic                 l1_valid_out,
  output logic [ADDR_BITS-1:0] l1_addr_out,
  output logic [511:0]         l1_value_out,
  input  logic                 l1_ready_in
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int IW = $clog2(LINES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Request FIFO
  logic [ADDR_BITS-1:0] q_addr  [QUEUE_DEPTH];
  logic                 q_we    [QUEUE_DEPTH];
  logic [511:0]         q_value [QUEUE_DEPTH];
  logic [QW-1:0]        wr_ptr;
  logic [QW-1:0]        rd_ptr;
  logic [QW:0]          count;
  logic [QW:0]          count_nxt;
  logic                 ready_q;

  logic [1:0]           state;
  logic [CW-1:0]        lat_cnt;

  logic [511:0]         store [LINES];
  logic [LINES-1:0]     line_vld;

  logic                 resp_vld_p1;
  logic [ADDR_BITS-1:0] resp_addr_p1;
  logic [511:0]         resp_value_p1;

  logic                 push;
  logic                 pop;
  logic                 exec_wr;
  logic                 resp_hs;
  logic [ADDR_BITS-1:0] head_addr;
  logic                 head_we;
  logic [511:0]         head_value;
  logic [IW-1:0]        head_idx;
  logic [511:0]         miss_line;
  logic [511:0]         rd_line;
  logic [ADDR_BITS-1:0] line_addr_in;
  logic [5:0]           unused_addr_bits;

`ifdef LC_RESP_INIT_PATTERN_EN
  function automatic logic [511:0] pattern_line(input logic [ADDR_BITS-1:0] base);
    logic [511:0] line;
    for (int w = 0; w < 8; w++) begin
      line[w*64 +: 64] = 64'(base) + 64'(8 * w);
    end
    return line;
  endfunction

  assign miss_line = pattern_line(head_addr);
`else
  assign miss_line = '0;
`endif

  assign unused_addr_bits = l1_addr_in[5:0];
  assign line_addr_in     = {l1_addr_in[ADDR_BITS-1:6], 6'b0};

  assign head_addr  = q_addr[rd_ptr];
  assign head_we    = q_we[rd_ptr];
  assign head_value = q_value[rd_ptr];
  // Higher address bits are dropped here, so line indices alias modulo LINES.
  assign head_idx   = head_addr[6 +: IW];
  assign rd_line    = line_vld[head_idx] ? store[head_idx] : miss_line;

  // A full FIFO is refused even if it pops this cycle: ready only reflects the registered occupancy.
  assign push    = l1_valid_in & ready_q;
  assign exec_wr = (state == ST_EXEC) & head_we;
  assign resp_hs = (state == ST_RESP) & l1_ready_in;
  assign pop     = exec_wr | resp_hs;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      q_addr[wr_ptr]  <= line_addr_in;
      q_we[wr_ptr]    <= l1_we_in;
      q_value[wr_ptr] <= l1_value_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && exec_wr) begin
      store[head_idx] <= head_value;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ready_q       <= 1'b0;
      state         <= ST_IDLE;
      lat_cnt       <= '0;
      line_vld      <= '0;
      resp_vld_p1   <= 1'b0;
      resp_addr_p1  <= '0;
      resp_value_p1 <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      ready_q <= (count_nxt != (QW+1)'(QUEUE_DEPTH));

      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            state   <= ST_WAIT;
            lat_cnt <= CW'(LATENCY - 1);
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) state <= ST_EXEC;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        // Response stage: read data is captured once and held until the L1 takes it.
        ST_EXEC: begin
          if (head_we) begin
            line_vld[head_idx] <= 1'b1;
            state              <= ST_IDLE;
          end else begin
            resp_vld_p1   <= 1'b1;
            resp_addr_p1  <= head_addr;
            resp_value_p1 <= rd_line;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (l1_ready_in) begin
            resp_vld_p1 <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign l1_ready_out = ready_q;
  assign l1_valid_out = resp_vld_p1;
  assign l1_addr_out  = resp_addr_p1;
  assign l1_value_out = resp_value_p1;

endmodule

// File: tb/tb_lc_line_responder.sv
// Bench for lc_line_responder: directed scenarios plus random traffic checked against a line-map reference model.
module tb_lc_line_responder;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         l1_valid_in;
  logic [63:0]  l1_addr_in;
  logic [511:0] l1_value_in;
  logic         l1_we_in;
  logic         l1_ready_out;
  logic         l1_valid_out;
  logic [63:0]  l1_addr_out;
  logic [511:0] l1_value_out;
  logic         l1_ready_in;

  lc_line_responder dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .l1_valid_in  (l1_valid_in),
    .l1_addr_in   (l1_addr_in),
    .l1_value_in  (l1_value_in),
    .l1_we_in     (l1_we_in),
    .l1_ready_out (l1_ready_out),
    .l1_valid_out (l1_valid_out),
    .l1_addr_out  (l1_addr_out),
    .l1_value_out (l1_value_out),
    .l1_ready_in  (l1_ready_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [63:0]  addr;
    logic         we;
    logic [511:0] value;
  } req_t;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] value;
  } resp_t;

  req_t         pend_q[$];
  resp_t        exp_q[$];
  logic [511:0] mem_model [int];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int last_acc = 0;
  int rise_cyc = 0;
  logic vprev = 1'b0;
  logic rand_ready = 1'b0;

`ifdef LC_RESP_INIT_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  function automatic int line_idx(input logic [63:0] a);
    return int'((a >> 6) % 64'd256);
  endfunction

  function automatic logic [511:0] miss_line(input logic [63:0] a);
    logic [511:0] l;
    for (int w = 0; w < 8; w++) begin
      l[w*64 +: 64] = PAT_EN ? ((a & ~64'h3f) + 64'(8 * w)) : 64'h0;
    end
    return l;
  endfunction

  function automatic logic [511:0] model_read(input logic [63:0] a);
    if (mem_model.exists(line_idx(a))) return mem_model[line_idx(a)];
    return miss_line(a);
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive_head();
    if (pend_q.size() > 0) begin
      l1_valid_in = 1'b1;
      l1_addr_in  = pend_q[0].addr;
      l1_we_in    = pend_q[0].we;
      l1_value_in = pend_q[0].value;
    end else begin
      l1_valid_in = 1'b0;
    end
  endtask

  task automatic enq(input logic [63:0] a, input logic we, input logic [511:0] v);
    req_t  r;
    resp_t e;
    r.addr = a; r.we = we; r.value = v;
    pend_q.push_back(r);
    if (we) begin
      mem_model[line_idx(a)] = v;
    end else begin
      e.addr  = a & ~64'h3f;
      e.value = model_read(a);
      exp_q.push_back(e);
    end
    drive_head();
  endtask

  // One clock: score handshakes seen in this cycle, advance, then re-drive inputs.
  task automatic tick();
    logic         acc, hs, hold;
    logic [63:0]  a0;
    logic [511:0] v0;
    req_t         dr;
    resp_t        de;
    acc  = l1_valid_in && l1_ready_out && !rst_in;
    hs   = l1_valid_out && l1_ready_in && !rst_in;
    hold = l1_valid_out && !l1_ready_in && !rst_in;
    a0   = l1_addr_out;
    v0   = l1_value_out;
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 1'b1, 1'b0);
      end else begin
        chk("resp_addr", a0, exp_q[0].addr);
        chk("resp_value", v0, exp_q[0].value);
        de = exp_q.pop_front();
      end
    end
    @(posedge clk_in);
    #1;
    cyc++;
    if (hold) begin
      chk("hold_valid", l1_valid_out, 1'b1);
      chk("hold_addr", l1_addr_out, a0);
      chk("hold_value", l1_value_out, v0);
    end
    if (acc) begin
      dr = pend_q.pop_front();
      n_acc++;
      last_acc = cyc;
    end
    if (!vprev && l1_valid_out) rise_cyc = cyc;
    vprev = l1_valid_out;
    if (rand_ready) l1_ready_in = 1'($urandom_range(0, 1));
    drive_head();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 1'((pend_q.size() == 0) && (exp_q.size() == 0)), 1'b1);
    repeat (60) tick();
  endtask

  initial begin
    logic [511:0] d;
    logic [63:0]  a;
    int           base_acc;
    int           n;

    rst_in = 1'b1;
    l1_valid_in = 1'b0;
    l1_addr_in = '0;
    l1_value_in = '0;
    l1_we_in = 1'b0;
    l1_ready_in = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ready", l1_ready_out, 1'b0);
    chk("rst_valid", l1_valid_out, 1'b0);
    chk("rst_addr", l1_addr_out, 64'h0);
    chk("rst_value", l1_value_out, 512'h0);
    rst_in = 1'b0;
    tick();
    chk("ready_after_rst", l1_ready_out, 1'b1);

    // Single read latency on an idle block
    l1_ready_in = 1'b1;
    enq(64'h1040, 1'b0, '0);
    drain(100);
    chk("read_latency", 32'(rise_cyc - last_acc), 32'd10);
    chk("valid_low_after_hs", l1_valid_out, 1'b0);

    // Write then read of the same line with unaligned address
    enq(64'h2000, 1'b1, {8{64'hA5A5_0000_0000_0001}});
    enq(64'h2013, 1'b0, '0);
    drain(200);

    // Aliased index: 0x4000 maps to line 0
    enq(64'h0000, 1'b1, rand_line());
    enq(64'h4000, 1'b0, '0);
    drain(200);

    // Back-to-back reads with the L1 stalling responses
    l1_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) enq(64'h6000 + 64'(i * 64), 1'b1, rand_line());
    drain(400);
    base_acc = n_acc;
    for (int i = 0; i < 5; i++) enq(64'h6000 + 64'(i * 64), 1'b0, '0);
    repeat (20) tick();
    chk("accepts_when_full", 32'(n_acc - base_acc), 32'd4);
    chk("ready_full", l1_ready_out, 1'b0);
    chk("stall_valid", l1_valid_out, 1'b1);
    chk("stall_addr", l1_addr_out, 64'h6000);
    repeat (3) tick();
    l1_ready_in = 1'b1;
    drain(400);

    // Reset while a response is pending
    enq(64'h5000, 1'b1, rand_line());
    enq(64'h5000, 1'b0, '0);
    drain(200);
    l1_ready_in = 1'b0;
    enq(64'h5040, 1'b0, '0);
    n = 0;
    while (!l1_valid_out && n < 80) begin
      tick();
      n++;
    end
    chk("resp_before_rst", l1_valid_out, 1'b1);
    rst_in = 1'b1;
    pend_q.delete();
    exp_q.delete();
    mem_model.delete();
    drive_head();
    tick();
    chk("rst_mid_resp_valid", l1_valid_out, 1'b0);
    chk("rst_mid_resp_ready", l1_ready_out, 1'b0);
    rst_in = 1'b0;
    tick();
    chk("ready_after_rst2", l1_ready_out, 1'b1);
    l1_ready_in = 1'b1;
    enq(64'h5000, 1'b0, '0);
    drain(200);

    // Alternating write/read pairs on one line
    for (int i = 0; i < 3; i++) begin
      enq(64'h3000, 1'b1, rand_line());
      enq(64'h3000 + 64'($urandom_range(0, 63)), 1'b0, '0);
    end
    drain(400);

    // Random traffic with random response back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = (64'($urandom_range(0, 15)) << 14) | (64'($urandom_range(0, 7)) << 6) | 64'($urandom_range(0, 63));
      d = rand_line();
      enq(a, 1'($urandom_range(0, 1)), d);
      repeat ($urandom_range(0, 6)) tick();
    end
    drain(4000);
    rand_ready = 1'b0;
    l1_ready_in = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lc_line_responder.md
Name: lc_line_responder

Overview:
- Lower-cache responder for the 512-bit line-granular lc_* interface that the L1 instruction and data caches drive as initiators.
- Accepts line read (fill) and write-back requests from one L1 and queues them in order.
- Services each request after a fixed latency against an internal line store, and returns read data with a valid/ready handshake.
- Stands in for L2/memory so that a single L1 can run closed-loop in simulation and at the top level.

Parameters:
- QUEUE_DEPTH, 4, request FIFO entries; power of two, >= 2.
- LATENCY, 8, cycles from the head request entering service to its read response or write commit; >= 1.
- LINES, 256, line-store entries of 64 B each; power of two.
- ADDR_BITS, 64, request/response address width.

Ports:
- clk_in  input  1  sole clock; all state updates on rising edge.
- rst_in  input  1  reset; synchronous, active-high.
- l1_valid_in  input  1  L1 presents a request.
- l1_addr_in  input  ADDR_BITS  request byte address; bits [5:0] ignored.
- l1_value_in  input  512  write-back line data; used only when l1_we_in=1.
- l1_we_in  input  1  1 = write-back, 0 = line read.
- l1_ready_out  output  1  responder can accept a request this cycle.
- l1_valid_out  output  1  read response valid.
- l1_addr_out  output  ADDR_BITS  line-aligned address of the response; bits [5:0]=0.
- l1_value_out  output  512  read line data.
- l1_ready_in  input  1  L1 accepts the response this cycle.

Behaviour:
- Interface: one clock (clk_in); reset is synchronous and active-high (rst_in).
- Reset values: l1_ready_out=0 during reset, then 1 from the first cycle after rst_in deasserts. l1_valid_out=0, l1_addr_out=0, l1_value_out=0.
- Reset also empties the FIFO, returns the FSM to IDLE, zeroes the latency counter and clears all line-valid bits. The store data array itself is not reset.
- Request accept: l1_valid_in & l1_ready_out in the same cycle. The entry {line addr, we, value} is pushed to the FIFO.
- l1_ready_out = !full, registered from current occupancy. A pop in the same cycle does not make a full FIFO accept.
- Ordering: strictly in-order, one request in service at a time.
- Line index: l1_addr_in[6 +: log2(LINES)]. Higher address bits are ignored, so indices alias and wrap modulo LINES.
- FSM states and transitions:
  - IDLE: FIFO non-empty -> WAIT; load counter with LATENCY-1.
  - WAIT: decrement counter each cycle; at 0 -> EXEC.
  - EXEC, write: store the line, set its valid bit, pop the entry -> IDLE. Writes produce no response.
  - EXEC, read: latch line data (all zeros if the valid bit is clear) and the aligned address into the outputs. Assert l1_valid_out -> RESP.
  - RESP: hold l1_valid_out, l1_addr_out and l1_value_out stable until l1_ready_in=1. On the handshake cycle, pop, deassert l1_valid_out next cycle -> IDLE.
- Latency: for a request accepted at cycle t into an empty, idle block, l1_valid_out rises at cycle t+LATENCY+2.
  - Minimum read round trip with l1_ready_in held high is LATENCY+3 cycles, accept to next IDLE.
- A read following a write to the same line always returns the written data, because requests are serviced in order.
- Simultaneous push and pop (not full): both take effect and occupancy is unchanged.
- l1_ready_in while l1_valid_out=0 is ignored.
- A request presented while l1_ready_out=0 is not captured. The L1 must hold it.
- Reset mid-RESP drops l1_valid_out the next cycle and discards the response.

Optional Feature:
- Macro: LC_RESP_INIT_PATTERN_EN.
- Defined: a read of a line whose valid bit is clear returns an address pattern. 64-bit word w (w=0..7, word 0 in bits [63:0]) equals line_base + 8*w, where line_base is the aligned request address at full ADDR_BITS.
- Not defined: such reads return all zeros.
- Written lines are unaffected either way.

Test Plan:
- Reset, then read addr 0x1040 with LATENCY=8 and l1_ready_in=1 -> l1_valid_out high exactly 10 cycles after accept, l1_addr_out=0x1040, value all zeros (pattern build: words 0x1040,0x1048,…,0x1078).
- Write line 0x2000 with value {8{64'hA5A5_0000_0000_0001}}, then read 0x2013 -> response addr 0x2000, value equals the written line.
- Issue 5 back-to-back reads with l1_ready_in=0 -> l1_ready_out falls after 4 accepts; the 5th is held off. l1_valid_out stays high with stable data until l1_ready_in=1.
- With LINES=256, write 0x0000 then read 0x4000 (aliased index 0) -> read returns the 0x0000 data, addr_out=0x4000.
- Assert rst_in during RESP -> next cycle l1_valid_out=0, FIFO empty; a later read of a previously written line returns zeros or the pattern.
- Alternate write/read to 0x3000 with different data, 3 pairs -> each read returns the immediately preceding write's data, in order.
